// File: rtl/reg_bank.sv
// rtl/reg_bank.sv - architectural register file with two read ports and pending-load scoreboard
//
// Purpose: NUM_REGS x DATA_W register file for the RISC core. One write port
// takes the selected writeback word; two combinational read ports feed
// decode/execute with write-through bypass. A busy bit per register tracks
// loads whose data has not yet returned, so control can stall on it.
//
// Ports:
//   clk        - system clock, all state updates on the rising edge
//   rst        - synchronous active-low reset
//   rs1, rs2   - read addresses
//   rd1, rd2   - read data (combinational)
//   reg_write  - write enable
//   rd         - write address
//   data_write - writeback word
//   load_issue - a load targeting load_rd was issued this cycle
//   load_rd    - destination register of the issued load
//   rs1_busy   - rs1 has an outstanding load
//   rs2_busy   - rs2 has an outstanding load
//   any_busy   - at least one load is outstanding

module reg_bank #(
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 32,
  parameter int                SP_INDEX = 29,
  parameter logic [DATA_W-1:0] SP_INIT  = 32'h0000_0FFC,
  localparam int               AW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              reg_write,
  input  logic [AW-1:0]     rd,
  input  logic [DATA_W-1:0] data_write,
  input  logic              load_issue,
  input  logic [AW-1:0]     load_rd,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              any_busy
);

  // One bit wider than an index so NUM_REGS itself is representable.
  localparam logic [AW:0] NUM_LIM = NUM_REGS[AW:0];

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;
  logic                wr_en;
  logic                ld_en;

  // True for a real, writable register: non-zero and inside the file
  // (only matters for non-power-of-two NUM_REGS).
  function automatic logic idx_live(input logic [AW-1:0] idx);
    return (idx != '0) && ({1'b0, idx} < NUM_LIM);
  endfunction

  assign wr_en = reg_write && idx_live(rd);
  assign ld_en = load_issue && idx_live(load_rd);

  // Set is applied after clear so a load issued on the same edge that the
  // previous load's data returns leaves the register outstanding.
  always_comb begin
    busy_next = busy;
    if (wr_en) busy_next[rd] = 1'b0;
    if (ld_en) busy_next[load_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_INDEX) ? SP_INIT : '0;
      end
      busy <= '0;
    end else begin
      if (wr_en) regs[rd] <= data_write;
      busy <= busy_next;
    end
  end

  // Read port 1: zero register and out-of-range read 0; a same-cycle write
  // to the addressed register is forwarded.
  always_comb begin
    rd1      = '0;
    rs1_busy = 1'b0;
    if (idx_live(rs1)) begin
      if (reg_write && rd == rs1) begin
        rd1 = data_write;
      end else begin
        rd1      = regs[rs1];
        rs1_busy = busy[rs1];
      end
    end
  end

  always_comb begin
    rd2      = '0;
    rs2_busy = 1'b0;
    if (idx_live(rs2)) begin
      if (reg_write && rd == rs2) begin
        rd2 = data_write;
      end else begin
        rd2      = regs[rs2];
        rs2_busy = busy[rs2];
      end
    end
  end

  assign any_busy = |busy;

endmodule

// File: tb/tb_reg_bank.sv
// tb/tb_reg_bank.sv - self-checking bench for reg_bank with a reference model
module tb_reg_bank;

  localparam logic [31:0] SP_INIT = 32'h0000_0FFC;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd, load_rd;
  logic [31:0] rd1, rd2, data_write;
  logic        reg_write, load_issue;
  logic        rs1_busy, rs2_busy, any_busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  reg_bank dut (
    .clk        (clk),
    .rst        (rst),
    .rs1        (rs1),
    .rs2        (rs2),
    .rd1        (rd1),
    .rd2        (rd2),
    .reg_write  (reg_write),
    .rd         (rd),
    .data_write (data_write),
    .load_issue (load_issue),
    .load_rd    (load_rd),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .any_busy   (any_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (reg_write && rd == a) return data_write;
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
    return m_busy[a] && !(reg_write && rd == a);
  endfunction

  function automatic logic exp_any();
    int cnt = 0;
    foreach (m_busy[i]) cnt += int'(m_busy[i]);
    return cnt > 0;
  endfunction

  // Let combinational outputs settle, then compare against the model.
  task automatic settle();
    #2;
    chk("rd1",      rd1,              exp_read(rs1));
    chk("rd2",      rd2,              exp_read(rs2));
    chk("rs1_busy", {31'b0, rs1_busy}, {31'b0, exp_busy(rs1)});
    chk("rs2_busy", {31'b0, rs2_busy}, {31'b0, exp_busy(rs2)});
    chk("any_busy", {31'b0, any_busy}, {31'b0, exp_any()});
  endtask

  // Advance one edge and apply the architectural effect of the inputs.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      foreach (m_regs[i]) begin
        m_regs[i] = (i == 29) ? SP_INIT : 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (reg_write && rd != 0) begin
        m_regs[rd] = data_write;
        m_busy[rd] = 1'b0;
      end
      if (load_issue && load_rd != 0) m_busy[load_rd] = 1'b1;
    end
    #1;
  endtask

  initial begin
    rst = 1'b0; rs1 = '0; rs2 = '0; rd = '0; load_rd = '0;
    data_write = '0; reg_write = 1'b0; load_issue = 1'b0;

    // Reset
    tick();
    rst = 1'b1; rs1 = 5'd29; rs2 = 5'd5;
    settle();
    chk("rst_sp",  rd1, SP_INIT);
    chk("rst_r5",  rd2, 32'h0);
    chk("rst_any", {31'b0, any_busy}, 32'h0);
    tick();

    // Write with bypass, then stored read
    reg_write = 1'b1; rd = 5'd7; data_write = 32'hDEAD_BEEF; rs1 = 5'd7;
    settle();
    chk("bypass_r7", rd1, 32'hDEAD_BEEF);
    tick();
    reg_write = 1'b0;
    settle();
    chk("stored_r7", rd1, 32'hDEAD_BEEF);
    tick();

    // Zero register
    rs2 = 5'd0; reg_write = 1'b1; rd = 5'd0; data_write = 32'h1234;
    settle();
    chk("r0_during", rd2, 32'h0);
    tick();
    reg_write = 1'b0; load_issue = 1'b1; load_rd = 5'd0;
    settle();
    chk("r0_after", rd2, 32'h0);
    tick();
    load_issue = 1'b0;
    settle();
    chk("r0_busy", {31'b0, rs2_busy}, 32'h0);
    chk("r0_any",  {31'b0, any_busy}, 32'h0);
    tick();

    // Load stall on r3
    load_issue = 1'b1; load_rd = 5'd3;
    settle();
    tick();
    load_issue = 1'b0; rs1 = 5'd3;
    settle();
    chk("r3_busy_set", {31'b0, rs1_busy}, 32'h1);
    tick();
    settle();
    tick();
    reg_write = 1'b1; rd = 5'd3; data_write = 32'h55;
    settle();
    chk("r3_busy_clr_comb", {31'b0, rs1_busy}, 32'h0);
    chk("r3_data_bypass",   rd1, 32'h55);
    tick();
    reg_write = 1'b0;
    settle();
    chk("r3_busy_clr_stored", {31'b0, rs1_busy}, 32'h0);
    chk("r3_any_clear",       {31'b0, any_busy}, 32'h0);
    tick();

    // Simultaneous clear and set on r4: set wins
    load_issue = 1'b1; load_rd = 5'd4;
    settle();
    tick();
    reg_write = 1'b1; rd = 5'd4; data_write = 32'h77; rs1 = 5'd4;
    settle();
    tick();
    reg_write = 1'b0; load_issue = 1'b0;
    settle();
    chk("r4_data",      rd1, 32'h77);
    chk("r4_busy_kept", {31'b0, rs1_busy}, 32'h1);
    tick();
    reg_write = 1'b1; rd = 5'd4; data_write = 32'h78;
    settle();
    tick();
    reg_write = 1'b0;

    // Reset mid-operation overrides write and issue
    load_issue = 1'b1; load_rd = 5'd3;
    settle();
    tick();
    load_issue = 1'b0; reg_write = 1'b1; rd = 5'd8; data_write = 32'hA5;
    settle();
    tick();
    reg_write = 1'b0; rs1 = 5'd8;
    settle();
    chk("pre_rst_r8",  rd1, 32'hA5);
    chk("pre_rst_any", {31'b0, any_busy}, 32'h1);
    rst = 1'b0; reg_write = 1'b1; rd = 5'd8; data_write = 32'hFFFF;
    load_issue = 1'b1; load_rd = 5'd9;
    tick();
    rst = 1'b1; reg_write = 1'b0; load_issue = 1'b0; rs1 = 5'd8; rs2 = 5'd29;
    settle();
    chk("post_rst_r8",  rd1, 32'h0);
    chk("post_rst_sp",  rd2, SP_INIT);
    chk("post_rst_any", {31'b0, any_busy}, 32'h0);
    tick();

    // Randomized traffic; addresses often confined to 0..7 to force collisions
    for (int i = 0; i < 600; i++) begin
      logic narrow;
      narrow     = ($urandom_range(0, 1) == 1);
      rst        = ($urandom_range(0, 63) != 0);
      reg_write  = ($urandom_range(0, 2) != 0);
      load_issue = ($urandom_range(0, 2) == 0);
      data_write = $urandom;
      rs1        = 5'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
      rs2        = 5'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
      rd         = 5'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
      load_rd    = 5'(narrow ? $urandom_range(0, 7) : $urandom_range(0, 31));
      settle();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
